icon_operand_receiver: RTL and testbench

ICON_OPERAND_RECEIVER -- requirements
Module: icon_operand_receiver

---
 rtl/pkg_dtypes.sv | 30 +++
 rtl/icon_rx_fifo.sv | 64 ++++++
 rtl/icon_operand_receiver.sv | 66 ++++++
 tb/tb_icon_operand_receiver.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_dtypes.sv
// Shared datatypes for the ICON broadcast interconnect and execution units.
// Holds the channel format and the operand-receiver buffer entry.
package pkg_dtypes;

    localparam int TOT_NUM_ICON_INTERFACES    = 8;
    localparam int DATA_WIDTH                 = 16;
    localparam int EXEC_UNIT_ADDR_WIDTH       = 3;
    localparam int ICON_RX_FIFO_DEPTH_DEFAULT = 4;

    typedef logic [DATA_WIDTH-1:0]           type_exec_unit_data;
    typedef logic [EXEC_UNIT_ADDR_WIDTH-1:0] type_exec_unit_addr;

    typedef struct packed {
        logic [TOT_NUM_ICON_INTERFACES-1:0] eus;
    } type_icon_eu_list;

    typedef struct packed {
        type_exec_unit_addr src_addr;
        type_exec_unit_data data;
        logic               data_valid;
        type_icon_eu_list   receiver_list;
        type_icon_eu_list   success_list;
    } type_icon_channel;

    typedef struct packed {
        type_exec_unit_addr src_addr;
        type_exec_unit_data data;
    } type_icon_rx_entry;

endpackage

// File: rtl/icon_rx_fifo.sv
// Operand buffer for icon_operand_receiver: circular storage with wrapping
// pointers and an occupancy count; storage itself is not reset.
module icon_rx_fifo
    import pkg_dtypes::*;
#(
    parameter int DEPTH = ICON_RX_FIFO_DEPTH_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic                     i_push,
    input  type_icon_rx_entry        i_push_entry,
    input  logic                     i_pop,
    output type_icon_rx_entry        o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    type_icon_rx_entry mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;
    assign o_head  = mem[rd_ptr];

    // Guard locally so a caller mistake can never corrupt the count.
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (do_push && i_nrst) begin
            mem[wr_ptr] <= i_push_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/icon_operand_receiver.sv
// Receives operands addressed to this execution unit from the ICON broadcast
// channel and buffers them for the ALU. Optional macro: ICON_RX_BYPASS_EN.
module icon_operand_receiver
    import pkg_dtypes::*;
#(
    parameter int RECEIVER_IDX = 0,
    parameter int FIFO_DEPTH   = ICON_RX_FIFO_DEPTH_DEFAULT
) (
    input  logic                          i_clk,
    input  logic                          i_nrst,
    input  type_icon_channel              i_channel,
    output logic                          o_success,
    output type_exec_unit_data            o_op_data,
    output type_exec_unit_addr            o_op_src_addr,
    output logic                          o_op_valid,
    input  logic                          i_op_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    logic              match;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    type_icon_rx_entry in_entry;
    type_icon_rx_entry head;
    logic              unused_chan;

    assign unused_chan = ^{i_channel.success_list, i_channel.receiver_list.eus};

    assign match    = i_channel.data_valid & i_channel.receiver_list.eus[RECEIVER_IDX];
    // Depends only on the channel and registered occupancy, never on i_op_ready.
    assign o_success = i_nrst & match & ~fifo_full;
    assign in_entry  = '{src_addr: i_channel.src_addr, data: i_channel.data};
    assign pop       = ~fifo_empty & i_op_ready;

`ifdef ICON_RX_BYPASS_EN
    logic bypass;

    assign bypass        = i_nrst & match & fifo_empty;
    assign push          = o_success & ~(bypass & i_op_ready);
    assign o_op_valid    = ~fifo_empty | bypass;
    assign o_op_data     = bypass ? i_channel.data     : head.data;
    assign o_op_src_addr = bypass ? i_channel.src_addr : head.src_addr;
`else
    assign push          = o_success;
    assign o_op_valid    = ~fifo_empty;
    assign o_op_data     = head.data;
    assign o_op_src_addr = head.src_addr;
`endif

    icon_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_push       (push),
        .i_push_entry (in_entry),
        .i_pop        (pop),
        .o_head       (head),
        .o_full       (fifo_full),
        .o_empty      (fifo_empty),
        .o_count      (o_count)
    );

endmodule

// File: tb/tb_icon_operand_receiver.sv
// Self-checking bench for icon_operand_receiver: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_icon_operand_receiver;
    import pkg_dtypes::*;

    localparam int RX    = 3;
    localparam int DEPTH = 4;

    logic               i_clk = 1'b0;
    logic               i_nrst;
    type_icon_channel   i_channel;
    logic               o_success;
    type_exec_unit_data o_op_data;
    type_exec_unit_addr o_op_src_addr;
    logic               o_op_valid;
    logic               i_op_ready;
    logic [2:0]         o_count;

    int errors = 0;
    int checks = 0;

    type_icon_rx_entry model_q[$];

    typedef struct {
        bit          nrst;
        bit          dv;
        logic [7:0]  eus;
        logic [15:0] data;
        bit          rdy;
        bit          e_succ;
        bit          e_valid;
        int          e_cnt;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl[$];

    icon_operand_receiver #(
        .RECEIVER_IDX (RX),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_nrst        (i_nrst),
        .i_channel     (i_channel),
        .o_success     (o_success),
        .o_op_data     (o_op_data),
        .o_op_src_addr (o_op_src_addr),
        .o_op_valid    (o_op_valid),
        .i_op_ready    (i_op_ready),
        .o_count       (o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [2:0] src_of(input logic [15:0] d);
        return d[2:0] ^ 3'h5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit nrst, input bit dv, input logic [7:0] eus,
                         input logic [15:0] data, input bit rdy);
        i_nrst                      = nrst;
        i_channel.data_valid        = dv;
        i_channel.receiver_list.eus = eus;
        i_channel.success_list.eus  = '0;
        i_channel.data              = data;
        i_channel.src_addr          = src_of(data);
        i_op_ready                  = rdy;
    endtask

    function automatic void add(input bit nrst, input bit dv, input logic [7:0] eus,
                                input logic [15:0] data, input bit rdy, input bit e_succ,
                                input bit e_valid, input int e_cnt, input logic [15:0] e_data);
        vec_t v;
        v.nrst = nrst; v.dv = dv; v.eus = eus; v.data = data; v.rdy = rdy;
        v.e_succ = e_succ; v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_data = e_data;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        drive(1'b0, 1'b1, 8'h08, 16'h0055, 1'b1);
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        model_q.delete();
    endtask

    initial begin
        @(negedge i_clk);
        do_reset();
        #1;
        chk("reset_success", o_success, 1'b0);
        chk("reset_valid", o_op_valid, 1'b0);
        chk("reset_count", o_count, 3'd0);
        drive(1'b1, 1'b0, 8'h00, 16'h0, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);

`ifndef ICON_RX_BYPASS_EN
        // Single push and one-cycle latency, then a non-matching receiver.
        add(1, 1, 8'h08, 16'h00A5, 0, 1, 0, 0, 16'h0);
        add(1, 0, 8'h00, 16'h0000, 0, 0, 1, 1, 16'h00A5);
        add(1, 0, 8'h00, 16'h0000, 1, 0, 1, 1, 16'h00A5);
        add(1, 1, 8'h04, 16'h0033, 0, 0, 0, 0, 16'h0);
        add(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0);
        // Fill, stall the fifth operand, release one slot, drain.
        add(1, 1, 8'h08, 16'h0001, 0, 1, 0, 0, 16'h0);
        add(1, 1, 8'h08, 16'h0002, 0, 1, 1, 1, 16'h0001);
        add(1, 1, 8'h08, 16'h0003, 0, 1, 1, 2, 16'h0001);
        add(1, 1, 8'h08, 16'h0004, 0, 1, 1, 3, 16'h0001);
        add(1, 1, 8'h08, 16'h0005, 0, 0, 1, 4, 16'h0001);
        add(1, 1, 8'h08, 16'h0005, 0, 0, 1, 4, 16'h0001);
        add(1, 1, 8'h08, 16'h0005, 0, 0, 1, 4, 16'h0001);
        add(1, 1, 8'h08, 16'h0005, 1, 0, 1, 4, 16'h0001);
        add(1, 1, 8'h08, 16'h0005, 0, 1, 1, 3, 16'h0002);
        add(1, 0, 8'h00, 16'h0000, 1, 0, 1, 4, 16'h0002);
        add(1, 0, 8'h00, 16'h0000, 1, 0, 1, 3, 16'h0003);
        add(1, 0, 8'h00, 16'h0000, 1, 0, 1, 2, 16'h0004);
        add(1, 0, 8'h00, 16'h0000, 1, 0, 1, 1, 16'h0005);
        add(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0);
        // Simultaneous push and pop at count 2.
        add(1, 1, 8'h08, 16'h0010, 0, 1, 0, 0, 16'h0);
        add(1, 1, 8'h08, 16'h0011, 0, 1, 1, 1, 16'h0010);
        add(1, 1, 8'h08, 16'h0012, 1, 1, 1, 2, 16'h0010);
        add(1, 0, 8'h00, 16'h0000, 0, 0, 1, 2, 16'h0011);
        // Reset with three operands buffered.
        add(1, 1, 8'h08, 16'h0013, 0, 1, 1, 2, 16'h0011);
        add(0, 1, 8'h08, 16'h0014, 0, 0, 1, 3, 16'h0011);
        add(1, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].nrst, tbl[i].dv, tbl[i].eus, tbl[i].data, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d_success", i), o_success, tbl[i].e_succ);
            chk($sformatf("vec%0d_valid", i), o_op_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_count", i), o_count, tbl[i].e_cnt);
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_data", i), o_op_data, tbl[i].e_data);
                chk($sformatf("vec%0d_src", i), o_op_src_addr, src_of(tbl[i].e_data));
            end
            @(posedge i_clk);
            @(negedge i_clk);
        end
`else
        // Empty receiver with ready ALU: operand passes straight through.
        drive(1'b1, 1'b1, 8'h08, 16'h0007, 1'b1);
        #1;
        chk("bypass_success", o_success, 1'b1);
        chk("bypass_valid", o_op_valid, 1'b1);
        chk("bypass_data", o_op_data, 16'h0007);
        chk("bypass_src", o_op_src_addr, src_of(16'h0007));
        @(posedge i_clk);
        @(negedge i_clk);
        drive(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
        #1;
        chk("bypass_count", o_count, 3'd0);
        chk("bypass_valid_after", o_op_valid, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
`endif

        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit          nrst;
            bit          dv;
            bit          rdy;
            bit          m;
            bit          e_succ;
            bit          e_valid;
            bit          bypass_hit;
            logic [7:0]  eus;
            logic [15:0] data;
            type_icon_rx_entry e_head;
            int          sz;

            nrst = ($urandom_range(0, 49) != 0);
            dv   = ($urandom_range(0, 3) != 0);
            eus  = 8'($urandom);
            eus[RX] = ($urandom_range(0, 9) < 6);
            data = 16'($urandom);
            rdy  = ($urandom_range(0, 2) == 0);
            drive(nrst, dv, eus, data, rdy);

            sz         = model_q.size();
            m          = dv && eus[RX];
            e_succ     = nrst && m && (sz < DEPTH);
            e_valid    = (sz != 0);
            e_head     = (sz != 0) ? model_q[0] : '{src_addr: '0, data: '0};
            bypass_hit = 1'b0;
`ifdef ICON_RX_BYPASS_EN
            if (nrst && m && sz == 0) begin
                bypass_hit = 1'b1;
                e_valid    = 1'b1;
                e_head     = '{src_addr: src_of(data), data: data};
            end
`endif
            #1;
            chk("rand_success", o_success, e_succ);
            chk("rand_valid", o_op_valid, e_valid);
            chk("rand_count", o_count, sz);
            if (e_valid) begin
                chk("rand_data", o_op_data, e_head.data);
                chk("rand_src", o_op_src_addr, e_head.src_addr);
            end
            @(posedge i_clk);
            if (!nrst) begin
                model_q.delete();
            end else if (!(bypass_hit && rdy)) begin
                if (sz != 0 && rdy) begin
                    void'(model_q.pop_front());
                end
                if (e_succ) begin
                    model_q.push_back('{src_addr: src_of(data), data: data});
                end
            end
            @(negedge i_clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
